// File: rtl/apb_master.sv
// APB master: one command at a time, accepted in IDLE and driven through the SETUP and ACCESS phases.
// Optional ACCESS-phase timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 2");
  end

  state_t              state_q;
  logic                cmd_ready_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_err_q;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q     <= SETUP;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: begin
          // Slave completion wins over an expiry landing on the same edge.
          if (pready) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : prdata;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic          pclk, preset_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (preset_n === 1'b1 && rsp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        mon_e = expq.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  // Each call lands on the IDLE negedge.
  task automatic idle_start();
    @(negedge pclk);
    pready = 1'b0;
    chk("idle_psel", psel, 0);
    chk("idle_penable", penable, 0);
    chk("idle_ready", cmd_ready, 1);
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit hold);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(negedge pclk);
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    chk("setup_pwdata", pwdata, d);
    if (hold) begin
      cmd_addr = ~a; cmd_wdata = ~d; cmd_write = ~w;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic access(input logic [AW-1:0] a, input logic [DW-1:0] d, input int waits, input logic [DW-1:0] rd);
    for (int i = 0; i <= waits; i++) begin
      @(negedge pclk);
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, a);
      chk("access_pwdata", pwdata, d);
      pready = (i == waits);
      prdata = (i == waits) ? rd : (32'hBAD0_0000 + DW'(i));
    end
  endtask

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int waits, input logic [DW-1:0] rd, input bit hold);
    exp_t e;
    e.rdata = w ? '0 : rd;
    e.err   = 1'b0;
    expq.push_back(e);
    idle_start();
    issue(w, a, d, hold);
    access(a, d, waits, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    exp_t e;
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; prdata = '0; pready = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    preset_n = 1'b1;

    xfer(1'b1, 32'h0000_A000, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0);
    xfer(1'b0, 32'h1234_0010, 32'h0,         3, 32'h1234_5678, 1'b0);
    xfer(1'b0, 32'h0000_0020, 32'h0,         0, 32'hCAFE_F00D, 1'b1);
    xfer(1'b1, 32'h0000_0024, 32'h0BAD_F00D, 1, 32'h1111_2222, 1'b0);
    xfer(1'b0, 32'h0000_0028, 32'h0,         2, 32'h8765_4321, 1'b0);
    idle_start();
    @(negedge pclk);
    chk("hold_rsp_valid", rsp_valid, 0);
    chk("hold_rsp_rdata", rsp_rdata, 32'h8765_4321);

`ifdef APB_MASTER_TIMEOUT_EN
    e.rdata = '0; e.err = 1'b1;
    expq.push_back(e);
    idle_start();
    issue(1'b0, 32'h0000_4000, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("to_psel", psel, 1);
      chk("to_penable", penable, 1);
      prdata = 32'hFFFF_0000;
    end
    idle_start();
    xfer(1'b0, 32'h0000_4004, 32'h0, 3, 32'hA5A5_5A5A, 1'b0);
`else
    xfer(1'b0, 32'h0000_4000, 32'h0, 20, 32'hA5A5_5A5A, 1'b0);
`endif
    idle_start();

    // Reset dropped mid-ACCESS must clear the bus without a clock edge.
    issue(1'b1, 32'h0000_3000, 32'h1357_9BDF, 1'b0);
    @(negedge pclk);
    chk("pre_rst_penable", penable, 1);
    #2 preset_n = 1'b0;
    #1;
    chk("async_rst_psel", psel, 0);
    chk("async_rst_penable", penable, 0);
    chk("async_rst_paddr", paddr, 0);
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_psel", psel, 0);
    @(negedge pclk);
    chk("post_rst_rsp_valid2", rsp_valid, 0);

    chk("scoreboard_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
